// File: rtl/rr_arbiter16_pkg.sv
// Shared types and sizes for the 16-requester round-robin arbiter.
package rr_arbiter16_pkg;

    localparam int NREQ  = 16;
    localparam int IDXW  = 4;
    localparam int HCNTW = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Turn a requester index into its one-hot grant pattern.
    function automatic logic [NREQ-1:0] idx2onehot(input logic [IDXW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter16_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter16_if;
    import rr_arbiter16_pkg::*;

    logic            enable;
    logic [NREQ-1:0] req_in;
    logic            release_in;
    logic [NREQ-1:0] grant_out;
    logic            grant_valid;

    modport master (
        output enable,
        output req_in,
        output release_in,
        input  grant_out,
        input  grant_valid
    );

    modport slave (
        input  enable,
        input  req_in,
        input  release_in,
        output grant_out,
        output grant_valid
    );

endinterface

// File: rtl/rr_arbiter16_pick.sv
// Combinational round-robin pick: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then add ptr back to recover the real index.
module rr_pick16
    import rr_arbiter16_pkg::*;
(
    input  logic [NREQ-1:0] i_req,
    input  logic [IDXW-1:0] i_ptr,
    output logic [IDXW-1:0] o_idx,
    output logic            o_any
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [IDXW-1:0]   w_off;

    // Doubling the vector makes the right shift a rotate.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NREQ-1:0];

    // Lowest set bit of the rotated vector; descending loop so the lowest wins.
    always_comb begin
        w_off = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = IDXW'(j);
            end
        end
    end

    // Modulo-16 add wraps naturally in the 4-bit index.
    assign o_idx = w_off + i_ptr;
    assign o_any = |i_req;

endmodule

// File: rtl/rr_arbiter16.sv
// 16-requester round-robin arbiter with registered one-hot grant, optional
// hold timeout and a mandatory idle cycle between consecutive grants.
module rr_arbiter16
    import rr_arbiter16_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 0
)
(
    input  logic          clk,
    input  logic          rst_n,
    rr_arbiter16_if.slave bus
);

    localparam bit               HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [HCNTW-1:0] HOLD_LAST = HCNTW'((HOLD_MAX == 0) ? 0 : HOLD_MAX - 1);

    state_t           r_state;
    logic [IDXW-1:0]  r_ptr;
    logic [HCNTW-1:0] r_hcnt;
    logic [NREQ-1:0]  r_grant;
    logic             r_valid;
    logic [IDXW-1:0]  r_gidx;

    state_t           w_state_nxt;
    logic [IDXW-1:0]  w_ptr_nxt;
    logic [HCNTW-1:0] w_hcnt_nxt;
    logic [NREQ-1:0]  w_grant_nxt;
    logic             w_valid_nxt;
    logic [IDXW-1:0]  w_gidx_nxt;

    logic [IDXW-1:0]  w_win;
    logic             w_any;
    logic             w_timeout;
    logic             w_release;

    rr_pick16 u_pick (
        .i_req (bus.req_in),
        .i_ptr (r_ptr),
        .o_idx (w_win),
        .o_any (w_any)
    );

    // All release causes collapse into one flag so ptr advances only once.
    assign w_timeout = HOLD_EN && (r_hcnt == HOLD_LAST);
    assign w_release = bus.release_in || !bus.req_in[r_gidx] || !bus.enable || w_timeout;

    // Next-state and next-output logic for the IDLE/GRANT machine.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        w_grant_nxt = r_grant;
        w_valid_nxt = r_valid;
        w_gidx_nxt  = r_gidx;
        case (r_state)
            IDLE: begin
                if (bus.enable && w_any) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = idx2onehot(w_win);
                    w_valid_nxt = 1'b1;
                    w_hcnt_nxt  = '0;
                    w_gidx_nxt  = w_win;
                end else begin
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            end
            GRANT: begin
                if (w_release) begin
                    // Dropping to zero here forces the bubble before any new grant.
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                    w_valid_nxt = 1'b0;
                    w_ptr_nxt   = r_gidx + IDXW'(1);
                end else if (r_hcnt != '1) begin
                    w_hcnt_nxt = r_hcnt + HCNTW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hcnt  <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_gidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_grant <= w_grant_nxt;
            r_valid <= w_valid_nxt;
            r_gidx  <= w_gidx_nxt;
        end
    end

    assign bus.grant_out   = r_grant;
    assign bus.grant_valid = r_valid;

    // The downstream encoder must only ever see zero or a single set bit.
    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(r_grant) && (r_valid == (|r_grant)));

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: an unlimited-hold instance and a HOLD_MAX=4
// instance share one stimulus; expected grants go through a queue.
module tb_rr_arbiter16;

    typedef struct packed {
        logic        en;
        logic        rel;
        logic [15:0] req;
        logic [15:0] gnt;
    } row_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        en    = 1'b0;
    logic        rel   = 1'b0;
    logic [15:0] req   = 16'h0000;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    rr_arbiter16_if if0();
    rr_arbiter16_if if4();

    assign if0.enable     = en;
    assign if0.req_in     = req;
    assign if0.release_in = rel;
    assign if4.enable     = en;
    assign if4.req_in     = req;
    assign if4.release_in = rel;

    rr_arbiter16 #(.HOLD_MAX(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    rr_arbiter16 #(.HOLD_MAX(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        en  = 1'b0;
        rel = 1'b0;
        req = 16'h0000;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [15:0] e;
        #12;
        n_checks++;
        if (if0.grant_out !== 16'h0000 || if0.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut0 grant=%h valid=%b expected grant=0000 valid=0", if0.grant_out, if0.grant_valid);
        end
        n_checks++;
        if (if4.grant_out !== 16'h0000 || if4.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut4 grant=%h valid=%b expected grant=0000 valid=0", if4.grant_out, if4.grant_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en  = 1'b1;
        req = 16'h0000;
        exp_q.push_back(16'h0000);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
            n_fail++;
            $display("FAIL reset_noreq grant=%h valid=%b expected grant=%h", if0.grant_out, if0.grant_valid, e);
        end
    endtask

    task automatic test_single();
        row_t rows [0:4];
        logic [15:0] e;
        rows = '{ {1'b1, 1'b0, 16'h0020, 16'h0020},
                  {1'b1, 1'b1, 16'h0020, 16'h0000},
                  {1'b1, 1'b0, 16'h0060, 16'h0040},
                  {1'b1, 1'b1, 16'h0060, 16'h0000},
                  {1'b1, 1'b0, 16'h0021, 16'h0001} };
        do_reset();
        foreach (rows[k]) begin
            en = rows[k].en; rel = rows[k].rel; req = rows[k].req;
            exp_q.push_back(rows[k].gnt);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL single[%0d] grant=%h valid=%b expected grant=%h", k, if0.grant_out, if0.grant_valid, e);
            end
        end
    endtask

    task automatic test_fairness();
        row_t rows [0:5];
        logic [15:0] e;
        rows = '{ {1'b1, 1'b0, 16'h8001, 16'h0001},
                  {1'b1, 1'b1, 16'h8001, 16'h0000},
                  {1'b1, 1'b0, 16'h8001, 16'h8000},
                  {1'b1, 1'b1, 16'h8001, 16'h0000},
                  {1'b1, 1'b0, 16'h8001, 16'h0001},
                  {1'b1, 1'b1, 16'h8001, 16'h0000} };
        do_reset();
        foreach (rows[k]) begin
            en = rows[k].en; rel = rows[k].rel; req = rows[k].req;
            exp_q.push_back(rows[k].gnt);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL fairness[%0d] grant=%h valid=%b expected grant=%h", k, if0.grant_out, if0.grant_valid, e);
            end
        end
    endtask

    task automatic test_wrap();
        row_t rows [0:8];
        logic [15:0] e;
        rows = '{ {1'b1, 1'b0, 16'h4000, 16'h4000},
                  {1'b1, 1'b1, 16'h4000, 16'h0000},
                  {1'b1, 1'b0, 16'h4003, 16'h0001},
                  {1'b1, 1'b1, 16'h4003, 16'h0000},
                  {1'b1, 1'b0, 16'h4003, 16'h0002},
                  {1'b1, 1'b1, 16'h4003, 16'h0000},
                  {1'b1, 1'b0, 16'h4003, 16'h4000},
                  {1'b1, 1'b1, 16'h4003, 16'h0000},
                  {1'b1, 1'b0, 16'h4003, 16'h0001} };
        do_reset();
        foreach (rows[k]) begin
            en = rows[k].en; rel = rows[k].rel; req = rows[k].req;
            exp_q.push_back(rows[k].gnt);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL wrap[%0d] grant=%h valid=%b expected grant=%h", k, if0.grant_out, if0.grant_valid, e);
            end
        end
    endtask

    task automatic test_timeout();
        logic [15:0] pat [0:6];
        logic [15:0] e;
        pat = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100};
        do_reset();
        en = 1'b1; rel = 1'b0; req = 16'h0100;
        foreach (pat[k]) begin
            exp_q.push_back(pat[k]);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if4.grant_out !== e || if4.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL timeout_h4[%0d] grant=%h valid=%b expected grant=%h", k, if4.grant_out, if4.grant_valid, e);
            end
            n_checks++;
            if (if0.grant_out !== 16'h0100 || if0.grant_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL timeout_unlimited[%0d] grant=%h valid=%b expected grant=0100", k, if0.grant_out, if0.grant_valid);
            end
        end
    endtask

    task automatic test_disable_drop();
        row_t rows [0:9];
        logic [15:0] e;
        rows = '{ {1'b1, 1'b0, 16'h0008, 16'h0008},
                  {1'b0, 1'b0, 16'h0008, 16'h0000},
                  {1'b0, 1'b0, 16'h0008, 16'h0000},
                  {1'b0, 1'b0, 16'h0008, 16'h0000},
                  {1'b1, 1'b0, 16'h0008, 16'h0008},
                  {1'b1, 1'b0, 16'h0000, 16'h0000},
                  {1'b1, 1'b0, 16'h0018, 16'h0010},
                  {1'b1, 1'b0, 16'h0019, 16'h0010},
                  {1'b1, 1'b0, 16'h0011, 16'h0010},
                  {1'b1, 1'b1, 16'h0011, 16'h0000} };
        do_reset();
        foreach (rows[k]) begin
            en = rows[k].en; rel = rows[k].rel; req = rows[k].req;
            exp_q.push_back(rows[k].gnt);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL disable_drop[%0d] grant=%h valid=%b expected grant=%h", k, if0.grant_out, if0.grant_valid, e);
            end
        end
    endtask

    task automatic test_async_reset();
        row_t rows [0:1];
        logic [15:0] e;
        rows = '{ {1'b1, 1'b0, 16'h0400, 16'h0400},
                  {1'b1, 1'b0, 16'h0400, 16'h0400} };
        do_reset();
        foreach (rows[k]) begin
            en = rows[k].en; rel = rows[k].rel; req = rows[k].req;
            exp_q.push_back(rows[k].gnt);
            tick();
            e = exp_q.pop_front();
            n_checks++;
            if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
                n_fail++;
                $display("FAIL async_pre[%0d] grant=%h valid=%b expected grant=%h", k, if0.grant_out, if0.grant_valid, e);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (if0.grant_out !== 16'h0000 || if0.grant_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear grant=%h valid=%b expected grant=0000 valid=0", if0.grant_out, if0.grant_valid);
        end
        req = 16'h0401;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(16'h0001);
        tick();
        e = exp_q.pop_front();
        n_checks++;
        if (if0.grant_out !== e || if0.grant_valid !== (e != 0)) begin
            n_fail++;
            $display("FAIL async_restart grant=%h valid=%b expected grant=%h", if0.grant_out, if0.grant_valid, e);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_timeout();
        test_disable_drop();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
